// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipelined control unit.
// ctrl_t is the bundle carried through ID/EX, EX/MEM and MEM/WB.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALU_MEM = 2'b00;
    localparam logic [1:0] ALU_BR  = 2'b01;
    localparam logic [1:0] ALU_FN  = 2'b10;
    localparam logic [1:0] ALU_LUI = 2'b11;

    localparam logic [1:0] JT_NONE = 2'b00;
    localparam logic [1:0] JT_JAL  = 2'b10;
    localparam logic [1:0] JT_JALR = 2'b01;

    typedef struct packed {
        logic                  valid;
        logic                  alu_src;
        logic                  mem_to_reg;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic [1:0]            alu_op;
        logic                  branch;
        logic [1:0]            jal_type;
        logic                  auipc;
        logic [2:0]            funct3;
        logic [REG_ADDR_W-1:0] rd;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// ID-side request and pipeline-control response bundle.
// master drives the ID stage inputs, slave is the control unit.
interface pipe_ctrl_unit_if #(
    parameter int ILL_CNT_W = 8
) ();
    import pipe_ctrl_pkg::*;

    logic                  id_valid_i;
    logic [6:0]            opcode_i;
    logic [2:0]            funct3_i;
    logic [REG_ADDR_W-1:0] rs1_i;
    logic [REG_ADDR_W-1:0] rs2_i;
    logic [REG_ADDR_W-1:0] rd_i;
    logic                  flush_i;
    logic                  hold_i;
    logic                  stall_o;
    ctrl_t                 ex_ctrl_o;
    ctrl_t                 mem_ctrl_o;
    ctrl_t                 wb_ctrl_o;
    logic                  illegal_o;
    logic [ILL_CNT_W-1:0]  ill_count_o;

    modport master (
        output id_valid_i, opcode_i, funct3_i,
        output rs1_i, rs2_i, rd_i, flush_i, hold_i,
        input  stall_o, ex_ctrl_o, mem_ctrl_o,
        input  wb_ctrl_o, illegal_o, ill_count_o
    );

    modport slave (
        input  id_valid_i, opcode_i, funct3_i,
        input  rs1_i, rs2_i, rd_i, flush_i, hold_i,
        output stall_o, ex_ctrl_o, mem_ctrl_o,
        output wb_ctrl_o, illegal_o, ill_count_o
    );

endinterface

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational main decoder: opcode/funct3/rd to a ctrl_t bundle,
// plus source-register usage and an illegal-opcode flag.
module ctrl_decode #(
    parameter bit ENABLE_AUIPC = 1'b1
) (
    input  logic                                 id_valid,
    input  logic [6:0]                           opcode,
    input  logic [2:0]                           funct3,
    input  logic [pipe_ctrl_pkg::REG_ADDR_W-1:0] rd,
    output pipe_ctrl_pkg::ctrl_t                 ctrl,
    output logic                                 uses_rs1,
    output logic                                 uses_rs2,
    output logic                                 illegal
);
    import pipe_ctrl_pkg::*;

    logic is_r, is_i, is_ld, is_st, is_br;
    logic is_jal, is_jalr, is_lui, is_auipc;
    logic legal;

    assign is_r     = opcode == OP_R;
    assign is_i     = opcode == OP_I;
    assign is_ld    = opcode == OP_LOAD;
    assign is_st    = opcode == OP_STORE;
    assign is_br    = opcode == OP_BRANCH;
    assign is_jal   = opcode == OP_JAL;
    assign is_jalr  = opcode == OP_JALR;
    assign is_lui   = opcode == OP_LUI;
    assign is_auipc = ENABLE_AUIPC && (opcode == OP_AUIPC);

    always_comb begin
        ctrl     = CTRL_BUBBLE;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        legal    = 1'b1;
        unique case (1'b1)
            is_r: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_FN;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            is_i: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_FN;
                uses_rs1       = 1'b1;
            end
            is_ld: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_op     = ALU_MEM;
                uses_rs1        = 1'b1;
            end
            is_st: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALU_MEM;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            is_br: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_BR;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
            end
            is_jal: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_FN;
                ctrl.jal_type  = JT_JAL;
            end
            is_jalr: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_FN;
                ctrl.jal_type  = JT_JALR;
                uses_rs1       = 1'b1;
            end
            is_lui: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_LUI;
            end
            is_auipc: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.auipc     = 1'b1;
                ctrl.alu_op    = ALU_MEM;
            end
            default: legal = 1'b0;
        endcase
        // illegal opcodes stay a pure all-zero bubble
        if (legal) begin
            ctrl.valid  = id_valid;
            ctrl.funct3 = funct3;
            ctrl.rd     = rd;
            if (rd == '0) ctrl.reg_write = 1'b0;
        end
    end

    assign illegal = ~legal;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control: decode in ID, ID/EX -> EX/MEM -> MEM/WB bundles,
// load-use stall, branch flush, global hold and illegal-opcode count.
module pipe_ctrl_unit #(
    parameter int REG_ADDR_W   = pipe_ctrl_pkg::REG_ADDR_W,
    parameter bit ENABLE_AUIPC = 1'b1,
    parameter int ILL_CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    pipe_ctrl_unit_if.slave   bus
);
    import pipe_ctrl_pkg::*;

    ctrl_t                 dec;
    ctrl_t                 ex_q;
    ctrl_t                 mem_q;
    ctrl_t                 wb_q;
    logic                  uses_rs1;
    logic                  uses_rs2;
    logic                  dec_illegal;
    logic                  rs1_hit;
    logic                  rs2_hit;
    logic                  hazard;
    logic                  accept;
    logic                  illegal_q;
    logic [ILL_CNT_W-1:0]  cnt_q;
    logic [REG_ADDR_W-1:0] ex_rd;

    ctrl_decode #(
        .ENABLE_AUIPC(ENABLE_AUIPC)
    ) u_decode (
        .id_valid (bus.id_valid_i),
        .opcode   (bus.opcode_i),
        .funct3   (bus.funct3_i),
        .rd       (bus.rd_i),
        .ctrl     (dec),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2),
        .illegal  (dec_illegal)
    );

    assign ex_rd   = ex_q.rd;
    assign rs1_hit = uses_rs1 && (bus.rs1_i == ex_rd);
    assign rs2_hit = uses_rs2 && (bus.rs2_i == ex_rd);

    assign hazard = bus.id_valid_i && ex_q.valid && ex_q.mem_read
                 && (ex_rd != '0) && (rs1_hit || rs2_hit);

    // a flush kills the dependent instruction, so it need not wait
    assign bus.stall_o = bus.hold_i || (hazard && !bus.flush_i);

    assign accept = !bus.hold_i && !bus.flush_i && !hazard
                 && bus.id_valid_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q      <= CTRL_BUBBLE;
            mem_q     <= CTRL_BUBBLE;
            wb_q      <= CTRL_BUBBLE;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else if (!bus.hold_i) begin
            mem_q     <= ex_q;
            wb_q      <= mem_q;
            ex_q      <= (bus.flush_i || hazard) ? CTRL_BUBBLE : dec;
            illegal_q <= accept && dec_illegal;
            if (accept && dec_illegal && (cnt_q != '1))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.ex_ctrl_o   = ex_q;
    assign bus.mem_ctrl_o  = mem_q;
    assign bus.wb_ctrl_o   = wb_q;
    assign bus.illegal_o   = illegal_q;
    assign bus.ill_count_o = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Randomised and directed bench for pipe_ctrl_unit, two DUTs
// (AUIPC enabled / disabled) against a table-driven pipeline model.
module tb_pipe_ctrl_unit;
    import pipe_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_unit_if #(.ILL_CNT_W(8)) bus_a ();
    pipe_ctrl_unit_if #(.ILL_CNT_W(8)) bus_b ();

    pipe_ctrl_unit #(
        .REG_ADDR_W(5), .ENABLE_AUIPC(1'b1), .ILL_CNT_W(8)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a.slave)
    );

    pipe_ctrl_unit #(
        .REG_ADDR_W(5), .ENABLE_AUIPC(1'b0), .ILL_CNT_W(8)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [19:0] m_ex  [2];
    logic [19:0] m_mem [2];
    logic [19:0] m_wb  [2];
    logic        m_ill [2];
    int          m_cnt [2];
    logic        s_a;

    logic [6:0] ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011,
                             7'b0100011, 7'b1100011, 7'b1101111,
                             7'b1100111, 7'b0110111, 7'b0010111,
                             7'b1111111, 7'b0000000};

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {legal, uses_rs1, uses_rs2, alu_src, mem_to_reg, reg_write,
    //  mem_read, mem_write, alu_op[1:0], branch, jal_type[1:0], auipc}
    function automatic logic [13:0] mtab(input bit en,
                                         input logic [6:0] op);
        case (op)
            7'b0110011: return {3'b111, 11'b00100_10_0_00_0};
            7'b0010011: return {3'b110, 11'b10100_10_0_00_0};
            7'b0000011: return {3'b110, 11'b11110_00_0_00_0};
            7'b0100011: return {3'b111, 11'b10001_00_0_00_0};
            7'b1100011: return {3'b111, 11'b00000_01_1_00_0};
            7'b1101111: return {3'b100, 11'b00100_10_0_10_0};
            7'b1100111: return {3'b110, 11'b10100_10_0_01_0};
            7'b0110111: return {3'b100, 11'b10100_11_0_00_0};
            7'b0010111: return en ? {3'b100, 11'b10100_00_0_00_1} : 14'd0;
            default:    return 14'd0;
        endcase
    endfunction

    function automatic logic [19:0] mdec(input bit en, input bit v,
            input logic [6:0] op, input logic [2:0] f3,
            input logic [4:0] rd);
        logic [13:0] t;
        logic [10:0] f;
        t = mtab(en, op);
        if (!t[13]) return 20'd0;
        f = t[10:0];
        if (rd == 5'd0) f[8] = 1'b0;
        return {v, f, f3, rd};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0;
            m_ill[k] = 1'b0; m_cnt[k] = 0;
        end
    endtask

    task automatic check_regs();
        logic [19:0] ax [2];
        logic [19:0] am [2];
        logic [19:0] aw [2];
        logic        ai [2];
        logic [7:0]  ac [2];
        ax[0] = bus_a.ex_ctrl_o;   ax[1] = bus_b.ex_ctrl_o;
        am[0] = bus_a.mem_ctrl_o;  am[1] = bus_b.mem_ctrl_o;
        aw[0] = bus_a.wb_ctrl_o;   aw[1] = bus_b.wb_ctrl_o;
        ai[0] = bus_a.illegal_o;   ai[1] = bus_b.illegal_o;
        ac[0] = bus_a.ill_count_o; ac[1] = bus_b.ill_count_o;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("ex_ctrl[%0d]", k), 32'(ax[k]), 32'(m_ex[k]));
            chk($sformatf("mem_ctrl[%0d]", k), 32'(am[k]), 32'(m_mem[k]));
            chk($sformatf("wb_ctrl[%0d]", k), 32'(aw[k]), 32'(m_wb[k]));
            chk($sformatf("illegal[%0d]", k), 32'(ai[k]), 32'(m_ill[k]));
            chk($sformatf("ill_count[%0d]", k), 32'(ac[k]), 32'(m_cnt[k]));
        end
    endtask

    task automatic drive(input bit v, input logic [6:0] op,
            input logic [2:0] f3, input logic [4:0] rs1,
            input logic [4:0] rs2, input logic [4:0] rd,
            input bit fl, input bit hd);
        bus_a.id_valid_i = v;  bus_b.id_valid_i = v;
        bus_a.opcode_i = op;   bus_b.opcode_i = op;
        bus_a.funct3_i = f3;   bus_b.funct3_i = f3;
        bus_a.rs1_i = rs1;     bus_b.rs1_i = rs1;
        bus_a.rs2_i = rs2;     bus_b.rs2_i = rs2;
        bus_a.rd_i = rd;       bus_b.rd_i = rd;
        bus_a.flush_i = fl;    bus_b.flush_i = fl;
        bus_a.hold_i = hd;     bus_b.hold_i = hd;
    endtask

    // one clock: drive after negedge, check stall, step model, check regs
    task automatic cycle(input bit v, input logic [6:0] op,
            input logic [2:0] f3, input logic [4:0] rs1,
            input logic [4:0] rs2, input logic [4:0] rd,
            input bit fl, input bit hd);
        logic [19:0] nx [2];
        logic [19:0] nm [2];
        logic [19:0] nw [2];
        logic        ni [2];
        int          nc [2];
        logic        as [2];
        logic [13:0] t;
        bit          haz, ill;
        drive(v, op, f3, rs1, rs2, rd, fl, hd);
        #1;
        as[0] = bus_a.stall_o;
        as[1] = bus_b.stall_o;
        s_a = as[0];
        for (int k = 0; k < 2; k++) begin
            t = mtab(k == 0, op);
            haz = v && m_ex[k][19] && m_ex[k][15] && (m_ex[k][4:0] != 0)
               && ((t[12] && rs1 == m_ex[k][4:0])
                || (t[11] && rs2 == m_ex[k][4:0]));
            chk($sformatf("stall[%0d]", k), 32'(as[k]),
                32'(hd || (haz && !fl)));
            nx[k] = m_ex[k]; nm[k] = m_mem[k]; nw[k] = m_wb[k];
            ni[k] = m_ill[k]; nc[k] = m_cnt[k];
            if (!hd) begin
                nw[k] = m_mem[k];
                nm[k] = m_ex[k];
                nx[k] = (fl || haz) ? 20'd0 : mdec(k == 0, v, op, f3, rd);
                ill = v && !fl && !haz && !t[13];
                ni[k] = ill;
                if (ill && m_cnt[k] < 255) nc[k] = m_cnt[k] + 1;
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            m_ex[k] = nx[k]; m_mem[k] = nm[k]; m_wb[k] = nw[k];
            m_ill[k] = ni[k]; m_cnt[k] = nc[k];
        end
        @(negedge clk);
        check_regs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 7'd0, 3'd0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        drive(0, 7'd0, 3'd0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        check_regs();
        reset_n = 1'b1;

        // decode literal and load-use
        cycle(1, OP_LOAD, 3'b010, 1, 0, 5, 0, 0);
        chk("lw_x5_lit", 32'(bus_a.ex_ctrl_o), 32'h000F8045);
        idle(1);
        cycle(1, OP_LOAD, 3'b010, 1, 0, 3, 0, 0);
        chk("lw_x3_lit", 32'(bus_a.ex_ctrl_o), 32'h000F8043);
        cycle(1, OP_R, 3'b000, 3, 1, 4, 0, 0);
        chk("lu_stall", 32'(s_a), 32'd1);
        chk("lu_bubble", 32'(bus_a.ex_ctrl_o), 32'd0);
        cycle(1, OP_R, 3'b000, 3, 1, 4, 0, 0);
        chk("lu_release", 32'(s_a), 32'd0);
        chk("add_lit", 32'(bus_a.ex_ctrl_o), 32'h00092004);
        cycle(1, OP_LOAD, 3'b010, 1, 0, 3, 0, 0);
        cycle(1, OP_LUI, 3'b000, 3, 3, 3, 0, 0);
        chk("lui_nostall", 32'(s_a), 32'd0);
        idle(3);

        // flush beats hazard
        cycle(1, OP_LOAD, 3'b010, 1, 0, 3, 0, 0);
        cycle(1, OP_R, 3'b000, 3, 1, 4, 1, 0);
        chk("flush_stall", 32'(s_a), 32'd0);
        chk("flush_bubble", 32'(bus_a.ex_ctrl_o), 32'd0);
        chk("flush_adv", 32'(bus_a.mem_ctrl_o), 32'h000F8043);

        // decode sweep, then ADDI to x0
        for (int i = 0; i < 9; i++)
            cycle(1, ops[i], 3'($urandom), 1, 2, 5, 0, 0);
        cycle(1, OP_I, 3'b000, 1, 0, 0, 0, 0);
        chk("addi_x0_rw", 32'(bus_a.ex_ctrl_o.reg_write), 32'd0);
        chk("addi_x0_v", 32'(bus_a.ex_ctrl_o.valid), 32'd1);
        idle(3);

        // hold with a full pipe
        cycle(1, OP_LOAD, 3'b000, 1, 0, 6, 0, 0);
        cycle(1, OP_STORE, 3'b001, 2, 7, 0, 0, 0);
        cycle(1, OP_BRANCH, 3'b100, 1, 2, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, OP_R, 3'b000, 6, 6, 8, 0, 1);
            chk("hold_stall", 32'(s_a), 32'd1);
        end
        idle(4);

        // mid-stream async reset with LW in EX and a nonzero count
        cycle(1, 7'h7F, 3'b000, 0, 0, 0, 0, 0);
        cycle(1, OP_LOAD, 3'b010, 1, 0, 3, 0, 0);
        #2;
        reset_n = 1'b0;
        bus_a.hold_i = 1'b1; bus_b.hold_i = 1'b1;
        #1;
        chk("rst_ex", 32'(bus_a.ex_ctrl_o), 32'd0);
        chk("rst_mem", 32'(bus_a.mem_ctrl_o), 32'd0);
        chk("rst_wb", 32'(bus_a.wb_ctrl_o), 32'd0);
        chk("rst_cnt", 32'(bus_a.ill_count_o), 32'd0);
        chk("rst_stall_hold", 32'(bus_a.stall_o), 32'd1);
        bus_a.hold_i = 1'b0; bus_b.hold_i = 1'b0;
        #1;
        chk("rst_stall", 32'(bus_a.stall_o), 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            int idx;
            logic [6:0] op;
            idx = $urandom_range(0, 10);
            op = (idx == 10) ? 7'($urandom) : ops[idx];
            cycle($urandom_range(0, 99) < 85, op, 3'($urandom),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 10);
        end

        // illegal counting and saturation
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cycle(1, OP_AUIPC, 3'b000, 0, 0, 9, 0, 0);
        chk("auipc_ill_b", 32'(bus_b.illegal_o), 32'd1);
        chk("auipc_ill_a", 32'(bus_a.illegal_o), 32'd0);
        chk("auipc_cnt_b", 32'(bus_b.ill_count_o), 32'd1);
        cycle(1, 7'h7F, 3'b000, 0, 0, 0, 1, 0);
        chk("flush_ill_cnt", 32'(bus_a.ill_count_o), 32'd0);
        chk("flush_ill_pulse", 32'(bus_a.illegal_o), 32'd0);
        for (int i = 0; i < 300; i++)
            cycle(1, 7'h7F, 3'b000, 0, 0, 0, 0, 0);
        chk("sat_a", 32'(bus_a.ill_count_o), 32'd255);
        chk("sat_b", 32'(bus_b.ill_count_o), 32'd255);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
